// File: rtl/riscv_pkg.sv
// Shared RV32 subset constants: opcodes, ALU function codes, controller states
// and immediate formats.
package riscv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLL = 3'b101,
    ALU_SRL = 3'b110
  } alu_func_e;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_MEM,
    ST_WB,
    ST_TRAP
  } state_e;

  typedef enum logic [1:0] {
    IMM_I,
    IMM_S,
    IMM_B
  } imm_fmt_e;

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate generator for I, S and B formats, sign-extended to 32 bits.
// Opcode bits never carry immediate data, so only instr[31:7] enters.
module imm_gen
  import riscv_pkg::*;
(
  input  logic [31:7] instr_i,
  input  logic [1:0]  fmt_i,
  output logic [31:0] imm_o
);

  always_comb begin
    imm_o = '0;
    case (imm_fmt_e'(fmt_i))
      IMM_S:   imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      IMM_B:   imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                        instr_i[30:25], instr_i[11:8], 1'b0};
      default: imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Non-pipelined RV32 subset controller: FETCH/DECODE/EXECUTE/MEM/WB with a
// sticky TRAP state for illegal instructions.
module multicycle_control
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  output logic [4:0]  rd_addr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic        alu_en,
  output logic [2:0]  alu_func,
  output logic [6:0]  alu_opcode,
  output logic [31:0] imm,
  output logic        alu_src_imm,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        rf_we,
  output logic        wb_sel_mem,
  output logic        retire,
  output logic        trap
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        f7b5;
  logic        is_r, is_i, is_load, is_store, is_branch;
  logic [1:0]  imm_fmt;
  alu_func_e   alu_sel;
  logic        alu_ok;
  logic        legal;
  logic        br_taken;
  logic [31:0] pc_plus4;
  logic [31:0] pc_branch;

  assign opcode    = ir_q[6:0];
  assign funct3    = ir_q[14:12];
  assign f7b5      = ir_q[30];
  assign is_r      = (opcode == OP_R);
  assign is_i      = (opcode == OP_I);
  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_branch = (opcode == OP_BRANCH);

  assign rs1_addr    = ir_q[19:15];
  assign rs2_addr    = ir_q[24:20];
  assign rd_addr     = ir_q[11:7];
  assign alu_opcode  = opcode;
  assign alu_func    = alu_sel;
  assign alu_src_imm = is_i || is_load || is_store;
  assign pc          = pc_q;
  assign trap        = (state_q == ST_TRAP);

  always_comb begin
    imm_fmt = IMM_I;
    if (is_store)       imm_fmt = IMM_S;
    else if (is_branch) imm_fmt = IMM_B;
  end

  imm_gen u_imm_gen (
    .instr_i (ir_q[31:7]),
    .fmt_i   (imm_fmt),
    .imm_o   (imm)
  );

  // funct7[5] selects SUB only for R-type; in I-type it is immediate bit 10.
  always_comb begin
    alu_sel = ALU_ADD;
    alu_ok  = 1'b1;
    if (is_r || is_i) begin
      case (funct3)
        3'b000:  alu_sel = (is_r && f7b5) ? ALU_SUB : ALU_ADD;
        3'b111:  alu_sel = ALU_AND;
        3'b110:  alu_sel = ALU_OR;
        3'b100:  alu_sel = ALU_XOR;
        3'b001:  alu_sel = ALU_SLL;
        3'b101: begin
          if (f7b5) alu_ok  = 1'b0;
          else      alu_sel = ALU_SRL;
        end
        default: alu_ok = 1'b0;
      endcase
    end
  end

  always_comb begin
    legal = 1'b0;
    if (is_r || is_i)         legal = alu_ok;
    else if (is_load || is_store) legal = 1'b1;
    else if (is_branch)       legal = (funct3 != 3'b010) && (funct3 != 3'b011);
  end

  always_comb begin
    case (funct3)
      3'b000:  br_taken = (rs1_data == rs2_data);
      3'b001:  br_taken = (rs1_data != rs2_data);
      3'b100:  br_taken = ($signed(rs1_data) <  $signed(rs2_data));
      3'b101:  br_taken = ($signed(rs1_data) >= $signed(rs2_data));
      3'b110:  br_taken = (rs1_data <  rs2_data);
      3'b111:  br_taken = (rs1_data >= rs2_data);
      default: br_taken = 1'b0;
    endcase
  end

  assign pc_plus4  = pc_q + 32'd4;
  assign pc_branch = pc_q + imm;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    alu_en     = 1'b0;
    rf_we      = 1'b0;
    wb_sel_mem = 1'b0;
    retire     = 1'b0;
    case (state_q)
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: state_d = legal ? ST_EXECUTE : ST_TRAP;
      ST_EXECUTE: begin
        alu_en = 1'b1;
        if (is_branch) begin
          pc_d    = br_taken ? pc_branch : pc_plus4;
          retire  = 1'b1;
          state_d = ST_FETCH;
        end else if (is_load || is_store) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_store;
        if (dmem_ack) begin
          if (is_store) begin
            pc_d    = pc_plus4;
            retire  = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end
      end
      ST_WB: begin
        rf_we      = (rd_addr != 5'd0);
        wb_sel_mem = is_load;
        pc_d       = pc_plus4;
        retire     = 1'b1;
        state_d    = ST_FETCH;
      end
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: scripted instruction stream with
// a scoreboard of expected retirements and register writes.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic [31:0] rs1_data, rs2_data;
  logic        alu_en;
  logic [2:0]  alu_func;
  logic [6:0]  alu_opcode;
  logic [31:0] imm;
  logic        alu_src_imm;
  logic        dmem_req, dmem_we, dmem_ack;
  logic        rf_we, wb_sel_mem, retire, trap;

  int          n_total = 0;
  int          n_bad   = 0;
  logic [31:0] mpc     = '0;
  logic [31:0] ret_q[$];
  logic [5:0]  wr_q[$];
  logic        pend    = 1'b0;
  logic [31:0] pend_pc = '0;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .pc          (pc),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rd_addr     (rd_addr),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .alu_en      (alu_en),
    .alu_func    (alu_func),
    .alu_opcode  (alu_opcode),
    .imm         (imm),
    .alu_src_imm (alu_src_imm),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_ack    (dmem_ack),
    .rf_we       (rf_we),
    .wb_sel_mem  (wb_sel_mem),
    .retire      (retire),
    .trap        (trap)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Scoreboard side: pops expected pc/write records when the DUT strobes.
  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        check("sb_next_pc", pc, pend_pc);
        pend = 1'b0;
      end
      if (retire) begin
        check("sb_retire_expected", 32'(ret_q.size() != 0), 32'd1);
        if (ret_q.size() != 0) begin
          pend_pc = ret_q.pop_front();
          pend    = 1'b1;
        end
      end
      if (rf_we) begin
        check("sb_write_expected", 32'(wr_q.size() != 0), 32'd1);
        if (wr_q.size() != 0) begin
          logic [5:0] w;
          w = wr_q.pop_front();
          check("sb_wb_rd", 32'(rd_addr), 32'(w[4:0]));
          check("sb_wb_sel", 32'(wb_sel_mem), 32'(w[5]));
        end
      end
    end
  end

  task automatic fetch(input logic [31:0] instr, input int waits);
    check("fetch_req", 32'(imem_req), 32'd1);
    imem_ack = 1'b0;
    for (int i = 0; i < waits; i++) begin
      @(negedge clk);
      check("fetch_hold", 32'(imem_req), 32'd1);
    end
    imem_rdata = instr;
    imem_ack   = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    check("decode_req_drop", 32'(imem_req), 32'd0);
    check("decode_alu_en", 32'(alu_en), 32'd0);
  endtask

  task automatic exec_check(input logic [2:0] f, input logic src, input logic [6:0] opc);
    @(negedge clk);
    check("exec_alu_en", 32'(alu_en), 32'd1);
    check("exec_func", 32'(alu_func), 32'(f));
    check("exec_src_imm", 32'(alu_src_imm), 32'(src));
    check("exec_opcode", 32'(alu_opcode), 32'(opc));
  endtask

  task automatic run_alu(input logic [31:0] instr, input int iw, input logic [2:0] f,
                         input logic src, input logic [6:0] opc, input logic [4:0] rd);
    ret_q.push_back(mpc + 32'd4);
    if (rd != 5'd0) wr_q.push_back({1'b0, rd});
    fetch(instr, iw);
    check("dec_rd", 32'(rd_addr), 32'(rd));
    exec_check(f, src, opc);
    @(negedge clk);
    check("wb_rf_we", 32'(rf_we), 32'(rd != 5'd0));
    check("wb_retire", 32'(retire), 32'd1);
    check("wb_dmem_req", 32'(dmem_req), 32'd0);
    @(negedge clk);
    mpc = mpc + 32'd4;
    check("alu_pc", pc, mpc);
  endtask

  task automatic run_mem(input logic [31:0] instr, input logic st, input int dw,
                         input logic [4:0] rd, input logic [31:0] exp_imm);
    ret_q.push_back(mpc + 32'd4);
    if (!st) wr_q.push_back({1'b1, rd});
    fetch(instr, 1);
    check("mem_imm", imm, exp_imm);
    exec_check(3'b000, 1'b1, st ? 7'b0100011 : 7'b0000011);
    @(negedge clk);
    for (int i = 0; i < dw; i++) begin
      check("mem_req_hold", 32'(dmem_req), 32'd1);
      check("mem_we", 32'(dmem_we), 32'(st));
      check("mem_no_retire", 32'(retire), 32'd0);
      @(negedge clk);
    end
    check("mem_req_last", 32'(dmem_req), 32'd1);
    dmem_ack = 1'b1;
    @(negedge clk);
    dmem_ack = 1'b0;
    if (!st) begin
      check("ld_wb_rf_we", 32'(rf_we), 32'd1);
      check("ld_wb_sel", 32'(wb_sel_mem), 32'd1);
      @(negedge clk);
    end else begin
      check("st_no_rf_we", 32'(rf_we), 32'd0);
      check("st_no_dmem_req", 32'(dmem_req), 32'd0);
    end
    mpc = mpc + 32'd4;
    check("mem_pc", pc, mpc);
  endtask

  task automatic run_br(input logic [31:0] instr, input logic [31:0] r1, input logic [31:0] r2,
                        input logic [31:0] exp_pc);
    ret_q.push_back(exp_pc);
    rs1_data = r1;
    rs2_data = r2;
    fetch(instr, 0);
    @(negedge clk);
    check("br_alu_en", 32'(alu_en), 32'd1);
    check("br_retire", 32'(retire), 32'd1);
    check("br_rf_we", 32'(rf_we), 32'd0);
    @(negedge clk);
    check("br_pc", pc, exp_pc);
    mpc = exp_pc;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog expired total=%0d bad=%0d", n_total, n_bad);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0; dmem_ack = 1'b0;
    rs1_data = '0; rs2_data = '0;
    #12;
    check("rst_pc", pc, 32'd0);
    check("rst_imem_req", 32'(imem_req), 32'd1);
    check("rst_trap", 32'(trap), 32'd0);
    check("rst_retire", 32'(retire), 32'd0);
    check("rst_rf_we", 32'(rf_we), 32'd0);
    check("rst_dmem_req", 32'(dmem_req), 32'd0);
    check("rst_alu_en", 32'(alu_en), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_alu(32'h002081B3, 2, 3'b000, 1'b0, 7'h33, 5'd3);       // add x3,x1,x2
    run_alu(32'h40208133, 0, 3'b001, 1'b0, 7'h33, 5'd2);       // sub x2,x1,x2
    run_alu(32'hFFF08093, 1, 3'b000, 1'b1, 7'h13, 5'd1);       // addi x1,x1,-1
    check("addi_imm", imm, 32'hFFFFFFFF);
    run_mem(32'h0040A183, 1'b0, 3, 5'd3, 32'd4);                // lw x3,4(x1)
    run_br(32'h00208463, 32'd5, 32'd5, 32'h18);                 // beq taken
    run_br(32'h00208463, 32'd5, 32'd6, 32'h1C);                 // beq not taken
    run_br(32'h0020C463, 32'hFFFFFFFF, 32'd1, 32'h24);          // blt -1<1
    run_br(32'h0020E463, 32'hFFFFFFFF, 32'd1, 32'h28);          // bltu not taken
    run_br(32'h0020D463, 32'hFFFFFFFF, 32'd1, 32'h2C);          // bge not taken
    run_mem(32'h0030A223, 1'b1, 1, 5'd4, 32'd4);                // sw x3,4(x1)
    dmem_ack = 1'b1;                                            // stray ack
    run_alu(32'h00000033, 0, 3'b000, 1'b0, 7'h33, 5'd0);       // add x0: no write
    dmem_ack = 1'b0;

    // Reset in the middle of a load's MEM phase.
    fetch(32'h0040A183, 0);
    exec_check(3'b000, 1'b1, 7'h03);
    @(negedge clk);
    check("mid_mem_req", 32'(dmem_req), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_pc", pc, 32'd0);
    check("mid_rst_imem_req", 32'(imem_req), 32'd1);
    check("mid_rst_dmem_req", 32'(dmem_req), 32'd0);
    check("mid_rst_retire", 32'(retire), 32'd0);
    check("mid_rst_rf_we", 32'(rf_we), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mpc = '0;

    run_br(32'hFE000EE3, 32'd7, 32'd7, 32'hFFFFFFFC);           // beq x0,x0,-4
    check("br_neg_imm", imm, 32'hFFFFFFFC);
    run_alu(32'h00000033, 0, 3'b000, 1'b0, 7'h33, 5'd0);       // pc wraps to 0
    run_alu(32'h002081B3, 0, 3'b000, 1'b0, 7'h33, 5'd3);

    fetch(32'h0020A1B3, 0);                                     // slt: illegal
    @(negedge clk);
    check("slt_trap", 32'(trap), 32'd1);
    check("slt_alu_en", 32'(alu_en), 32'd0);
    imem_ack = 1'b1;
    dmem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("trap_sticky", 32'(trap), 32'd1);
      check("trap_imem_req", 32'(imem_req), 32'd0);
      check("trap_dmem_req", 32'(dmem_req), 32'd0);
      check("trap_retire", 32'(retire), 32'd0);
      check("trap_rf_we", 32'(rf_we), 32'd0);
      check("trap_pc_frozen", pc, 32'h4);
    end
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    check("trap_rst_clear", 32'(trap), 32'd0);
    check("trap_rst_pc", pc, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    fetch(32'h0000007F, 1);                                     // bad opcode
    @(negedge clk);
    check("op7f_trap", 32'(trap), 32'd1);
    check("op7f_alu_en", 32'(alu_en), 32'd0);
    @(negedge clk);
    check("op7f_retire", 32'(retire), 32'd0);

    check("sb_retire_left", 32'(ret_q.size()), 32'd0);
    check("sb_write_left", 32'(wr_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have port: clk  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-003 SHALL have ports: imem_req  output  1  fetch request; imem_ack  input  1  instruction valid; imem_rdata  input  32  instruction word.
REQ-004 SHALL have port: pc  output  32  address of the current instruction.
REQ-005 SHALL have ports: rs1_addr, rs2_addr, rd_addr  output  5 each  register-file addresses from the held instruction.
REQ-006 SHALL have ports: rs1_data, rs2_data  input  32 each  register-file read data, used for branch compare.
REQ-007 SHALL have ports: alu_en  output  1; alu_func  output  3; alu_opcode  output  7; imm  output  32; alu_src_imm  output  1  (1 selects imm as ALU operand B).
REQ-008 SHALL have ports: dmem_req  output  1; dmem_we  output  1; dmem_ack  input  1.
REQ-009 SHALL have ports: rf_we  output  1  one-cycle register write strobe; wb_sel_mem  output  1  (1 selects load data, 0 selects ALU result).
REQ-010 SHALL have ports: retire  output  1  one-cycle pulse per completed instruction; trap  output  1  sticky illegal-instruction flag.

Function
REQ-011 SHALL sequence states FETCH, DECODE, EXECUTE, MEM, WB, TRAP; one instruction in flight, no overlap.
REQ-012 FETCH SHALL hold imem_req=1 until imem_ack=1, latch imem_rdata into the instruction register on that edge, then go to DECODE; imem_req SHALL drop in DECODE.
REQ-013 DECODE SHALL last exactly 1 cycle: generate imm (I, S, B formats, sign-extended to 32 bits), drive rs1/rs2/rd addresses, check legality; illegal instructions go to TRAP, others to EXECUTE.
REQ-014 Legal opcodes SHALL be 0110011 (R), 0010011 (I), 0000011 (load), 0100011 (store), 1100011 (branch); any other opcode is illegal.
REQ-015 alu_func mapping SHALL be:
- funct3 000 -> ADD 000, or SUB 001 when R-type and funct7[5]=1
- 111 -> AND 010
- 110 -> OR 011
- 100 -> XOR 100
- 001 -> SLL 101
- 101 with funct7[5]=0 -> SRL 110
- funct3 010, 011, or 101 with funct7[5]=1 in R/I -> illegal.
REQ-016 Loads and stores SHALL drive alu_func=ADD and alu_src_imm=1; I-type SHALL drive alu_src_imm=1; R-type SHALL drive alu_src_imm=0.
REQ-017 EXECUTE SHALL last 1 cycle with alu_en=1 and alu_opcode equal to the instruction opcode; alu_en SHALL be 0 in every other state.
REQ-018 From EXECUTE, the FSM SHALL go R/I -> WB, load/store -> MEM, branch -> FETCH.
REQ-019 Branch in EXECUTE SHALL resolve from rs1_data/rs2_data:
- funct3 000 BEQ, 001 BNE, 100 BLT signed, 101 BGE signed, 110 BLTU, 111 BGEU
- taken: pc <= pc + imm_b; not taken: pc <= pc + 4
- retire pulses.
REQ-020 Branch funct3 010/011 SHALL be illegal.
REQ-021 MEM SHALL hold dmem_req=1 (dmem_we=1 for store) until dmem_ack=1; then load -> WB, store -> FETCH with pc <= pc + 4 and retire=1.
REQ-022 WB SHALL last 1 cycle with rf_we=1, wb_sel_mem=1 for load (else 0), pc <= pc + 4, retire=1, then go to FETCH.
REQ-023 rf_we SHALL be 0 when rd_addr=0; the FSM still passes through WB.
REQ-024 PC arithmetic SHALL be 32-bit modulo: 0xFFFFFFFC + 4 = 0x00000000.
REQ-025 TRAP SHALL set trap=1, hold all request/strobe outputs at 0 and freeze pc; only reset leaves TRAP.
REQ-026 An ack arriving in a state that is not waiting for it SHALL be ignored.

Reset
REQ-027 rst_n=0 SHALL immediately force state=FETCH, pc=0, instruction register=0 (NOP-free, decoded as illegal only after a fetch), trap=0, and all strobes (imem_req excepted) to 0.
REQ-028 After reset release, imem_req SHALL be 1 in the first FETCH cycle.
REQ-029 Reset mid-MEM or mid-FETCH SHALL abandon the transfer with no retire, rf_we or pc change.

Structure
REQ-030 Opcode constants, ALU func codes (ADD..SRL) and the state encoding SHALL live in shared package riscv_pkg, also used by the ALU.
REQ-031 Immediate generation SHALL be a sub-module imm_gen (instr in, format select in, imm out, combinational).

Verification
REQ-032 Test ADD: 0x002081B3 (add x3,x1,x2), imem_ack after 2 waits -> EXECUTE with alu_func=000, alu_src_imm=0; WB with rf_we=1, rd_addr=3; pc 0 -> 4; retire once.
REQ-033 Test SUB: 0x40208133 -> alu_func=001; ADDI 0xFFF08093 -> imm=0xFFFFFFFF, alu_src_imm=1.
REQ-034 Test load/store: lw 0x0040A183 -> MEM with dmem_we=0, held 3 cycles until dmem_ack, then WB with wb_sel_mem=1. sw 0x0030A223 -> dmem_we=1, no rf_we.
REQ-035 Test branch: beq x1,x2,+8 (0x00208463) with rs1_data=rs2_data=5 -> pc 0x10 -> 0x18. rs2_data=6 -> pc 0x14. blt with -1 vs 1 -> taken.
REQ-036 Test illegal: opcode 0x7F or slt 0x0020A1B3 -> trap=1, no strobes; further acks ignored until rst_n=0.
REQ-037 Test reset during MEM: dmem_req=1, rst_n pulsed low -> pc=0 and FETCH without waiting for a clock edge, no retire.
